// File: rtl/pll_ctrl_pkg.sv
// Shared types and helpers for the PLL reset controllers.
// State encodings are fixed so state_o can be decoded by debug tools.
// FAILED exists only when PLL_USB_RETRY_LIMIT_EN is defined.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILISE = 3'd2,
`ifdef PLL_USB_RETRY_LIMIT_EN
        RUNNING   = 3'd3,
        FAILED    = 3'd4
`else
        RUNNING   = 3'd3
`endif
    } pllState_t;

    // Width of a down-counter able to hold the largest of the three loads.
    function automatic int counterWidth(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer for a PLL locked flag arriving asynchronously.
// Async active-low clear forces the synchronized output to "not locked".
module pll_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw locked flag through the synchronizer chain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_usb_reset_ctrl.sv
// USB PLL reset sequencer: pulses the PLL reset, waits for a qualified lock,
// retries on timeout and releases the downstream domain reset once lock has
// been stable. Optional macro PLL_USB_RETRY_LIMIT_EN adds a terminal FAILED
// state reached after MAX_RETRIES retries.
module pll_usb_reset_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int RST_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 50000,
    parameter int LOCK_STABLE  = 1024,
    parameter int MAX_RETRIES  = 7,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       pll_locked,
    input  logic       soft_reset_req,
    output logic       pll_rst,
    output logic       domain_reset_n,
    output logic       ready,
    output logic       lock_lost,
    output logic [3:0] retry_count,
    output logic [2:0] state_o
);

    localparam int CNT_W = counterWidth(RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
    localparam logic [CNT_W-1:0] RST_LOAD     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LOAD  = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    pllState_t        r_state;
    pllState_t        w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_curCnt;
    logic [CNT_W-1:0] w_loadVal;
    logic [CNT_W-1:0] w_nextCnt;
    logic [3:0]       r_retry;
    logic [3:0]       w_nextRetry;
    logic             r_lost;
    logic             w_nextLost;
    logic             r_armed;
    logic             r_pllRst;
    logic             r_domRstN;
    logic             r_ready;
    logic             w_nextPllRst;
    logic             w_lk;

    pll_lock_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_lockSync (
        .i_clk   (clk),
        .i_rst_n (reset_n),
        .i_async (pll_locked),
        .o_sync  (w_lk)
    );

    // Next-state, counter, retry and sticky-flag decisions; soft reset wins over everything.
    always_comb begin
        w_nextState  = r_state;
        w_nextRetry  = r_retry;
        w_nextLost   = r_lost;
        w_loadVal    = '0;
        w_nextCnt    = '0;
        w_nextPllRst = 1'b0;
        // The first cycle after reset release counts as entry into RESET_PLL.
        w_curCnt     = r_armed ? r_cnt : RST_LOAD;

        if (soft_reset_req) begin
            w_nextState = RESET_PLL;
            w_nextRetry = '0;
            w_nextLost  = 1'b0;
        end else begin
            case (r_state)
                RESET_PLL: begin
                    if (w_curCnt == '0) w_nextState = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (w_lk) begin
                        w_nextState = STABILISE;
                    end else if (w_curCnt == '0) begin
                        w_nextRetry = (r_retry == 4'hF) ? r_retry : r_retry + 4'd1;
                        w_nextState = RESET_PLL;
`ifdef PLL_USB_RETRY_LIMIT_EN
                        if (r_retry == 4'(MAX_RETRIES)) w_nextState = FAILED;
`endif
                    end
                end
                STABILISE: begin
                    if (!w_lk) begin
                        w_nextState = WAIT_LOCK;
                    end else if (w_curCnt == '0) begin
                        w_nextState = RUNNING;
                    end
                end
                RUNNING: begin
                    if (!w_lk) begin
                        w_nextLost  = 1'b1;
                        w_nextState = RESET_PLL;
                    end
                end
`ifdef PLL_USB_RETRY_LIMIT_EN
                FAILED: begin
                    w_nextState = FAILED;
                end
`endif
                default: begin
                    w_nextState = RESET_PLL;
                end
            endcase
        end

        case (w_nextState)
            RESET_PLL: w_loadVal = RST_LOAD;
            WAIT_LOCK: w_loadVal = TIMEOUT_LOAD;
            STABILISE: w_loadVal = STABLE_LOAD;
            default:   w_loadVal = '0;
        endcase

        if (soft_reset_req || (w_nextState != r_state)) begin
            w_nextCnt = w_loadVal;
        end else if (w_curCnt != '0) begin
            w_nextCnt = w_curCnt - CNT_ONE;
        end

        w_nextPllRst = (w_nextState == RESET_PLL);
`ifdef PLL_USB_RETRY_LIMIT_EN
        if (w_nextState == FAILED) w_nextPllRst = 1'b1;
`endif
    end

    // State, shared counter, status and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= RESET_PLL;
            r_cnt     <= '0;
            r_retry   <= '0;
            r_lost    <= 1'b0;
            r_armed   <= 1'b0;
            r_pllRst  <= 1'b1;
            r_domRstN <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cnt     <= w_nextCnt;
            r_retry   <= w_nextRetry;
            r_lost    <= w_nextLost;
            r_armed   <= 1'b1;
            r_pllRst  <= w_nextPllRst;
            r_domRstN <= (w_nextState == RUNNING);
            r_ready   <= (w_nextState == RUNNING);
        end
    end

    assign pll_rst        = r_pllRst;
    assign domain_reset_n = r_domRstN;
    assign ready          = r_ready;
    assign lock_lost      = r_lost;
    assign retry_count    = r_retry;
    assign state_o        = r_state;

endmodule

// File: tb/tb_pll_usb_reset_ctrl.sv
// Directed testbench for pll_usb_reset_ctrl with small timing parameters.
// Expected values are hand-computed from the sequencing rules; the FAILED
// scenario runs only when PLL_USB_RETRY_LIMIT_EN is defined.
module tb_pll_usb_reset_ctrl;

    logic       clk;
    logic       reset_n;
    logic       pll_locked;
    logic       soft_reset_req;
    logic       pll_rst;
    logic       domain_reset_n;
    logic       ready;
    logic       lock_lost;
    logic [3:0] retry_count;
    logic [2:0] state_o;

    int total;
    int bad;

    pll_usb_reset_ctrl #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (100),
        .LOCK_STABLE  (8),
        .MAX_RETRIES  (2),
        .SYNC_STAGES  (2)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .pll_locked     (pll_locked),
        .soft_reset_req (soft_reset_req),
        .pll_rst        (pll_rst),
        .domain_reset_n (domain_reset_n),
        .ready          (ready),
        .lock_lost      (lock_lost),
        .retry_count    (retry_count),
        .state_o        (state_o)
    );

    // Free-running reference clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Advance n rising edges and settle just after the last one.
    task automatic applyStimulus(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkStatus(input string tag, input int st, input int prst, input int drn, input int lost, input int rc);
        checkOutput({tag, ".state"}, 32'(state_o), 32'(st));
        checkOutput({tag, ".pll_rst"}, 32'(pll_rst), 32'(prst));
        checkOutput({tag, ".domain_reset_n"}, 32'(domain_reset_n), 32'(drn));
        checkOutput({tag, ".ready"}, 32'(ready), 32'(drn));
        checkOutput({tag, ".lock_lost"}, 32'(lock_lost), 32'(lost));
        checkOutput({tag, ".retry_count"}, 32'(retry_count), 32'(rc));
    endtask

    // Main directed sequence; edge numbers in comments count from reset release.
    initial begin
        total          = 0;
        bad            = 0;
        reset_n        = 1'b0;
        pll_locked     = 1'b0;
        soft_reset_req = 1'b0;
        applyStimulus(3);
        checkStatus("reset", 0, 1, 0, 0, 0);

        @(posedge clk);
        #1 reset_n = 1'b1;

        // Power-up: pll_rst high for edges 1..3, WAIT_LOCK at edge 4.
        applyStimulus(3);
        checkStatus("rstPulse", 0, 1, 0, 0, 0);
        applyStimulus(1);
        checkStatus("waitLock", 1, 0, 0, 0, 0);
        applyStimulus(5);
        pll_locked = 1'b1;
        applyStimulus(2);
        checkStatus("syncDelay", 1, 0, 0, 0, 0);
        applyStimulus(1);
        checkStatus("stabEntry", 2, 0, 0, 0, 0);
        applyStimulus(7);
        checkStatus("stabLast", 2, 0, 0, 0, 0);
        applyStimulus(1);
        checkStatus("running", 3, 0, 1, 0, 0);

        // Lock drop for 3 cycles in RUNNING, then relock.
        pll_locked = 1'b0;
        applyStimulus(2);
        checkStatus("dropSync", 3, 0, 1, 0, 0);
        applyStimulus(1);
        checkStatus("dropReset", 0, 1, 0, 1, 0);
        pll_locked = 1'b1;
        applyStimulus(3);
        checkStatus("dropPulse", 0, 1, 0, 1, 0);
        applyStimulus(1);
        checkStatus("dropWait", 1, 0, 0, 1, 0);
        applyStimulus(1);
        checkStatus("dropStab", 2, 0, 0, 1, 0);
        applyStimulus(8);
        checkStatus("relocked", 3, 0, 1, 1, 0);

        // Lock lost for good: three timeouts, 104 cycles apart.
        pll_locked = 1'b0;
        applyStimulus(3);
        checkStatus("lostAgain", 0, 1, 0, 1, 0);
        applyStimulus(4);
        checkStatus("toWait", 1, 0, 0, 1, 0);
        applyStimulus(99);
        checkStatus("toLast", 1, 0, 0, 1, 0);
        applyStimulus(1);
        checkStatus("timeout1", 0, 1, 0, 1, 1);
        applyStimulus(104);
        checkStatus("timeout2", 0, 1, 0, 1, 2);
        applyStimulus(104);
        checkStatus("timeout3", 0, 1, 0, 1, 3);

        // Glitch: locked high for 5 cycles, dropping during STABILISE.
        pll_locked = 1'b1;
        applyStimulus(5);
        checkStatus("glitchStab", 2, 0, 0, 1, 3);
        pll_locked = 1'b0;
        applyStimulus(2);
        checkStatus("glitchHold", 2, 0, 0, 1, 3);
        applyStimulus(1);
        checkStatus("glitchBack", 1, 0, 0, 1, 3);

        // Relock, then soft reset clears lock_lost and retry_count.
        pll_locked = 1'b1;
        applyStimulus(11);
        checkStatus("runBeforeSoft", 3, 0, 1, 1, 3);
        soft_reset_req = 1'b1;
        applyStimulus(1);
        soft_reset_req = 1'b0;
        checkStatus("softReset", 0, 1, 0, 0, 0);

        // Soft reset inside RESET_PLL restarts the full 4-cycle window.
        applyStimulus(2);
        soft_reset_req = 1'b1;
        applyStimulus(1);
        soft_reset_req = 1'b0;
        applyStimulus(3);
        checkStatus("restartHold", 0, 1, 0, 0, 0);
        applyStimulus(1);
        checkStatus("restartWait", 1, 0, 0, 0, 0);
        applyStimulus(9);
        checkStatus("restartRun", 3, 0, 1, 0, 0);

        // Soft reset coincides with the lock-drop decision: lock_lost stays 0.
        pll_locked = 1'b0;
        applyStimulus(2);
        checkStatus("prioPre", 3, 0, 1, 0, 0);
        soft_reset_req = 1'b1;
        applyStimulus(1);
        soft_reset_req = 1'b0;
        checkStatus("prioSoft", 0, 1, 0, 0, 0);

        // Retry counter climbs once per 104 cycles and saturates at 15.
        for (int k = 1; k <= 16; k++) begin
            applyStimulus(104);
            checkOutput("satRetry", 32'(retry_count), (k > 15) ? 32'd15 : 32'(k));
            checkOutput("satState", 32'(state_o), 32'd0);
        end

        // Asynchronous reset mid-cycle clears everything at once.
        applyStimulus(50);
        #2 reset_n = 1'b0;
        #1;
        checkStatus("asyncReset", 0, 1, 0, 0, 0);

`ifdef PLL_USB_RETRY_LIMIT_EN
        // Retry limit: third timeout with MAX_RETRIES=2 lands in FAILED.
        @(posedge clk);
        #1 reset_n = 1'b1;
        applyStimulus(104);
        checkStatus("lim1", 0, 1, 0, 0, 1);
        applyStimulus(104);
        checkStatus("lim2", 0, 1, 0, 0, 2);
        applyStimulus(104);
        checkStatus("failed", 4, 1, 0, 0, 3);
        applyStimulus(50);
        checkStatus("failedHold", 4, 1, 0, 0, 3);
        soft_reset_req = 1'b1;
        applyStimulus(1);
        soft_reset_req = 1'b0;
        checkStatus("failedSoft", 0, 1, 0, 0, 0);
        applyStimulus(4);
        checkStatus("failedRestart", 1, 0, 0, 0, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
